// File: rtl/popcount_arbiter.sv
// -----------------------------------------------------------------------------
// popcount_arbiter
//
// Two-requester round-robin front end wrapped around one shared
// shift-register / ones-counter datapath. A winner is chosen in IDLE, its
// operand is latched in LOAD, SHIFT strips one bit per cycle and stops as
// soon as the register holds no more set bits, and DONE returns the count
// with a one-cycle pulse to the requester that was served.
//
// Parameters
//   N       operand width (N >= 2)
//   CW      result width; must be able to hold the value N
//
// Ports
//   clock   rising-edge clock for all state
//   reset   synchronous, active-high; abandons any operation in progress
//   req     per-requester level request, bit i belongs to requester i
//   d0, d1  operands of requester 0 and 1, sampled in the gnt cycle
//   gnt     one-hot grant, high only in the LOAD cycle
//   busy    high in LOAD, SHIFT and DONE
//   done    one-hot completion pulse, high only in the DONE cycle
//   result  popcount of the last served operand, held until the next DONE
//   last    index of the most recently granted requester
// -----------------------------------------------------------------------------
module popcount_arbiter #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [N-1:0]  d0,
    input  logic [N-1:0]  d1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [1:0]    done,
    output logic [CW-1:0] result,
    output logic          last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  sreg;
    logic [CW-1:0] count;

    logic          grant_valid;
    logic          grant_idx;
    logic [N-1:0]  operand;
    logic          sreg_empty;

    // -------------------------------------------------------------------------
    // Arbitration. Only meaningful in IDLE. A lone request wins outright; when
    // both are asserted the requester that was not served last time wins,
    // which makes service alternate while both stay high.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        grant_valid = 1'b0;
        grant_idx   = last;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last;
            end
            default: ;
        endcase
    end

    // last already names the winner from the LOAD cycle onward, so it doubles
    // as the operand select and as the index for gnt and done.
    assign operand    = last ? d1 : d0;
    assign sreg_empty = (sreg == '0);

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                // Early termination: once no set bits remain, the count is
                // final regardless of how many bit positions are left.
                if (sreg_empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs decoded from the state. gnt and done live in different
    // states, so they can never overlap, and each has exactly one bit set.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt  = 2'b00;
        done = 2'b00;
        busy = 1'b0;
        case (state)
            LOAD: begin
                gnt[last] = 1'b1;
                busy      = 1'b1;
            end
            SHIFT: begin
                busy = 1'b1;
            end
            DONE: begin
                done[last] = 1'b1;
                busy       = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Arbitration memory and datapath. Reset puts last at 1 so requester 0
    // holds first priority, and clears the datapath so an abandoned operation
    // leaves nothing behind.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            last   <= 1'b1;
            sreg   <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last <= grant_idx;
                    end
                end
                LOAD: begin
                    sreg  <= operand;
                    count <= '0;
                end
                SHIFT: begin
                    if (sreg_empty) begin
                        // Publish on the SHIFT->DONE edge so result is valid
                        // in the same cycle as the done pulse.
                        result <= count;
                    end else begin
                        // count stays <= N, and CW holds N, so no overflow.
                        count <= count + {{(CW-1){1'b0}}, sreg[0]};
                        sreg  <= sreg >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_arbiter.sv
// -----------------------------------------------------------------------------
// tb_popcount_arbiter
//
// Directed and randomized bench for popcount_arbiter. Expected grant winner,
// done latency and result come from a small behavioural model: the winner
// from the round-robin rule, the latency from the position of the highest set
// bit, and the result from a plain count of ones.
// -----------------------------------------------------------------------------
module tb_popcount_arbiter;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [N-1:0]  d0;
    logic [N-1:0]  d1;
    logic [1:0]    gnt;
    logic          busy;
    logic [1:0]    done;
    logic [CW-1:0] result;
    logic          last;

    int tests  = 0;
    int failed = 0;

    // Behavioural model state.
    logic          model_last   = 1'b1;
    logic [CW-1:0] model_result = '0;

    always #5 clock = ~clock;

    popcount_arbiter #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .d0     (d0),
        .d1     (d1),
        .gnt    (gnt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .last   (last)
    );

    // Advance one cycle and settle away from the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [N-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(v[i]);
        return n;
    endfunction

    // Index of highest set bit plus one; 0 for an all-zero operand.
    function automatic int height(input logic [N-1:0] v);
        int h = 0;
        for (int i = 0; i < N; i++) if (v[i]) h = i + 1;
        return h;
    endfunction

    // Entered in an IDLE cycle t0; drives req_t0 so it is sampled at the end
    // of t0, follows the operation through done, and returns in the IDLE
    // cycle after done with req = req_end.
    task automatic run_op(input string tag, input logic [1:0] req_t0,
                          input logic [N-1:0] op0, input logic [N-1:0] op1,
                          input logic [1:0] req_mid, input logic [1:0] req_end);
        logic          w;
        logic [N-1:0]  opw;
        logic [1:0]    onehot;
        logic [CW-1:0] prev;
        int            lat;
        int            bad;
        w      = (req_t0 == 2'b11) ? ~model_last : req_t0[1];
        onehot = w ? 2'b10 : 2'b01;
        opw    = w ? op1 : op0;
        lat    = height(opw) + 3;
        prev   = model_result;
        req = req_t0;
        d0  = op0;
        d1  = op1;
        tick();  // t0+1
        check({tag, " gnt"}, gnt, onehot);
        check({tag, " gnt-cycle busy/done"}, {busy, done}, 3'b100);
        model_last = w;
        req = req_mid;
        bad = 0;
        for (int c = 2; c < lat; c++) begin
            tick();
            if (c == 2) begin
                // Operand is don't-care once the gnt cycle has passed.
                d0 = N'($urandom);
                d1 = N'($urandom);
            end
            if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b1 ||
                result !== prev || last !== w) bad++;
        end
        check({tag, " shift-phase violations"}, bad, 0);
        tick();  // t0+lat
        model_result = CW'(ones(opw));
        check({tag, " done"}, done, onehot);
        check({tag, " result"}, result, model_result);
        check({tag, " done-cycle busy/gnt/last"}, {busy, gnt, last}, {1'b1, 2'b00, w});
        req = req_end;
        tick();  // IDLE after done
        check({tag, " idle busy/gnt/done"}, {busy, gnt, done}, 5'b0);
        check({tag, " result held"}, result, model_result);
    endtask

    task automatic idle(input string tag, input int n);
        int bad = 0;
        req = 2'b00;
        repeat (n) begin
            tick();
            if ({busy, gnt, done} !== 5'b0 || result !== model_result ||
                last !== model_last) bad++;
        end
        check({tag, " idle violations"}, bad, 0);
    endtask

    initial begin
        logic [1:0]   r;
        logic [N-1:0] o0;
        logic [N-1:0] o1;

        // Reset values, with both requests already high.
        reset = 1'b1;
        req   = 2'b11;
        d0    = 8'h0F;
        d1    = 8'hF0;
        tick();
        tick();
        check("reset gnt/done/busy", {gnt, done, busy}, 5'b0);
        check("reset result", result, 4'd0);
        check("reset last", last, 1'b1);
        reset = 1'b0;

        // Contention straight out of reset: first grant must be 01, then
        // alternate; latencies 7 (0x0F) and 11 (0xF0), 2-cycle done->gnt gap.
        run_op("contend#1", 2'b11, 8'h0F, 8'hF0, 2'b11, 2'b11);
        run_op("contend#2", 2'b11, 8'h0F, 8'hF0, 2'b11, 2'b11);
        run_op("contend#3", 2'b11, 8'h0F, 8'hF0, 2'b11, 2'b11);
        run_op("contend#4", 2'b11, 8'h0F, 8'hF0, 2'b11, 2'b00);
        idle("after contend", 3);

        // Single request, result must hold afterwards.
        run_op("single B2", 2'b01, 8'hB2, 8'h00, 2'b01, 2'b00);
        idle("hold B2", 5);

        // Boundary operands on requester 1.
        run_op("d1=00", 2'b10, 8'h5A, 8'h00, 2'b10, 2'b00);
        run_op("d1=01", 2'b10, 8'h5A, 8'h01, 2'b10, 2'b00);
        run_op("d1=FF", 2'b10, 8'h5A, 8'hFF, 2'b10, 2'b00);
        idle("after boundary", 2);

        // Reset in the 4th SHIFT cycle of d0 = 0xFF.
        req = 2'b01;
        d0  = 8'hFF;
        d1  = 8'h00;
        tick();  // LOAD
        check("rst-mid gnt", gnt, 2'b01);
        req = 2'b00;
        repeat (4) tick();  // 4th SHIFT cycle
        check("rst-mid busy before reset", {busy, done}, 3'b100);
        reset = 1'b1;
        tick();
        check("rst-mid busy/gnt/done in reset", {busy, gnt, done}, 5'b0);
        check("rst-mid result", result, 4'd0);
        check("rst-mid last", last, 1'b1);
        model_last   = 1'b1;
        model_result = '0;
        reset = 1'b0;
        idle("rst-mid no done pulse", 12);
        run_op("rst-mid req1", 2'b10, 8'h00, 8'h3C, 2'b10, 2'b00);

        // Request dropped mid-operation: done still pulses, no new grant.
        run_op("drop req0", 2'b01, 8'hA5, 8'h00, 2'b00, 2'b00);
        idle("drop req0 no regrant", 15);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            r  = 2'($urandom_range(1, 3));
            o0 = N'($urandom) & N'((32'd1 << $urandom_range(0, N)) - 32'd1);
            o1 = N'($urandom) & N'((32'd1 << $urandom_range(0, N)) - 32'd1);
            run_op("random", r, o0, o1, 2'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle("random gap", $urandom_range(1, 3));
        end
        idle("final", 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/popcount_arbiter.md
# popcount_arbiter

Two-requester round-robin scheduler that time-shares a single shift-register/ones-counter datapath. The block arbitrates between requesters, loads the winner's operand, and sequences the shift/count steps with early termination. It returns the population count with a one-cycle done pulse to the winner. The shift register and counter are internal; the block replaces a standalone control unit for a single-client shifter.

## Interface
- N, default 8: operand width, N ≥ 2.
- CW, default $clog2(N+1) (4 for N=8): result width; it must hold the value N.

- clock  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- req  in  2  per-requester level request; bit i belongs to requester i.
- d0  in  N  operand of requester 0.
- d1  in  N  operand of requester 1.
- gnt  out  2  one-hot; high only during the LOAD cycle; marks the requester whose operand is latched.
- busy  out  1  high in the LOAD, SHIFT and DONE states.
- done  out  2  one-hot, one-cycle pulse in the DONE state to the served requester.
- result  out  CW  popcount of the last served operand; holds until the next DONE.
- last  out  1  index of the most recently granted requester.

## Operation
- Registered state machine with states IDLE, LOAD, SHIFT and DONE.
- **IDLE**
  - If req == 0, stay in IDLE.
  - If exactly one req bit is high, grant that requester.
  - If both req bits are high, grant requester !last.
  - On a grant, set last to the winner and go to LOAD.
- **LOAD**
  - gnt[winner] = 1.
  - sreg <= d_winner; count <= 0; go to SHIFT.
- **SHIFT**
  - If sreg == 0: go to DONE; count is unchanged.
  - Otherwise: count <= count + sreg[0]; sreg <= sreg >> 1; stay in SHIFT.
- **DONE**
  - done[winner] = 1; result holds count, registered on the SHIFT→DONE edge.
  - Next state is IDLE unconditionally.
- **Width rules**
  - count and result are CW bits, zero-extended.
  - count never exceeds N, so there is no overflow.
- **req handling**
  - req is sampled only in IDLE.
  - Dropping req mid-operation does not abort; done still pulses.
  - req is not a queue. A req still high in the IDLE cycle after its done is a new request, so requesters deassert req in the done cycle.
- **Operand stability:** d_winner must be stable in the gnt cycle and is don't-care afterwards.
- **Reset**, taking effect from any state including mid-operation:
  - state = IDLE, gnt = 0, done = 0, busy = 0.
  - result = 0, last = 1 (requester 0 has first priority), sreg = 0, count = 0.
  - An operation in progress is abandoned with no done pulse.

## Timing
- Let t0 be the IDLE cycle in which req is sampled high.
- Let h be the index of the highest set bit of the operand plus 1, with h = 0 for an operand of 0.
- Cycle by cycle:
  - gnt is high at t0+1.
  - SHIFT runs for h+1 cycles, t0+2 to t0+h+2.
  - done and the new result appear at t0+h+3.
  - busy is high from t0+1 to t0+h+3 inclusive.
- Latency range for N=8: from 3 cycles (d=0) to 11 cycles (MSB set).
- Back-to-back service: DONE, IDLE, LOAD. The minimum gap between a done and the next gnt is 2 cycles; there is no grant in the DONE cycle.
- A req arriving during busy waits; it is arbitrated in the next IDLE.
- Simultaneous requests arriving in one IDLE cycle are resolved by last, and service alternates while both stay asserted.
- gnt and done are mutually exclusive in time and never have more than one bit set.

## Test plan
- **Reset values:** assert reset for 2 cycles with req = 2'b11. Require:
  - gnt = 0, done = 0, busy = 0, result = 0, last = 1 while reset is high.
  - After release, the first gnt is 2'b01.
- **Single request:** req0 = 1 at t0 with d0 = 8'hB2. Require:
  - gnt = 2'b01 at t0+1.
  - done = 2'b01 at t0+11 with result = 4.
  - result holds 4 afterwards.
- **Boundary operands:**
  - d1 = 8'h00 gives done at t0+3 with result = 0.
  - d1 = 8'h01 gives done at t0+4 with result = 1.
  - d1 = 8'hFF gives done at t0+11 with result = 8 (4'b1000, no overflow).
- **Contention:** req = 2'b11 held continuously after reset, with d0 = 8'h0F and d1 = 8'hF0. Require:
  - Grants alternate 01, 10, 01, ...
  - Results alternate 4 and 4; done latencies are 7 and 11 cycles.
  - The gap from each done to the next gnt is 2 cycles.
- **Reset mid-operation:** assert reset in the 4th SHIFT cycle of d0 = 8'hFF. Require:
  - No done pulse.
  - result = 0 and last = 1 after reset.
  - A following req1 is granted normally.
- **Request dropped mid-operation:** req0 falls during SHIFT. Require:
  - done[0] still pulses with the correct count.
  - No further grant to requester 0 occurs.
